// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multicycle RISC-V control unit.
// Optional feature macro: BNE_SUPPORT_EN (adds BNE handling in BRANCH).
package multicycle_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned CNT_W   = 8;

    // Major opcodes handled by this controller
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [F3_W-1:0] F3_OR      = 3'b110;
    localparam logic [F3_W-1:0] F3_AND     = 3'b111;
    localparam logic [F3_W-1:0] F3_BEQ     = 3'b000;
`ifdef BNE_SUPPORT_EN
    localparam logic [F3_W-1:0] F3_BNE     = 3'b001;
`endif

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;

    localparam logic [SRC_W-1:0] SRC_A_PC     = 2'b00;
    localparam logic [SRC_W-1:0] SRC_A_RS1    = 2'b01;
    localparam logic [SRC_W-1:0] SRC_A_OLD_PC = 2'b10;
    localparam logic [SRC_W-1:0] SRC_B_RS2    = 2'b00;
    localparam logic [SRC_W-1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [SRC_W-1:0] SRC_B_IMM    = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd10
    } state_e;

    // Datapath control word produced each cycle
    typedef struct packed {
        logic             pc_write;
        logic             pc_src;
        logic             ir_write;
        logic             mem_read;
        logic             mem_write;
        logic             i_or_d;
        logic             reg_write;
        logic             mem_to_reg;
        logic [SRC_W-1:0] alu_src_a;
        logic [SRC_W-1:0] alu_src_b;
        logic [ALU_W-1:0] alu_ctrl;
        logic             instr_done;
        logic             fault;
    } ctrl_t;

    // States that wait on mem_ready and are guarded by the timeout counter
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction fields and status in, control out.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [OPC_W-1:0]   opcode;
    logic [F3_W-1:0]    funct3;
    logic               funct7_5;
    logic               zero;
    logic               mem_ready;

    logic               pc_write;
    logic               pc_src;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               i_or_d;
    logic               reg_write;
    logic               mem_to_reg;
    logic [SRC_W-1:0]   alu_src_a;
    logic [SRC_W-1:0]   alu_src_b;
    logic [ALU_W-1:0]   alu_ctrl;
    logic               instr_done;
    logic               fault;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
               instr_done, fault, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
               instr_done, fault, state
    );

endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU operation select per controller state; flags unsupported R-type funct3.
module mc_alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  state_e           state,
    input  logic [F3_W-1:0]  funct3,
    input  logic             funct7_5,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             illegal
);

    always_comb begin
        alu_ctrl = ALU_AND;
        illegal  = 1'b0;
        case (state)
            S_FETCH, S_DECODE, S_MEM_ADDR: alu_ctrl = ALU_ADD;
            S_BRANCH:                      alu_ctrl = ALU_SUB;
            S_EXEC_R: begin
                case (funct3)
                    F3_ADD_SUB: alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    F3_AND:     alu_ctrl = ALU_AND;
                    F3_OR:      alu_ctrl = ALU_OR;
                    default:    illegal  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V controller FSM (ld/sd/R-type/beq) with memory-wait timeout.
// Optional: define BNE_SUPPORT_EN to execute BNE instead of faulting on it.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);

    localparam int unsigned CNT_X_W = CNT_W + 1;
    localparam logic [CNT_X_W-1:0] TIMEOUT_LIM = CNT_X_W'(TIMEOUT_CYCLES);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout;
    logic [ALU_W-1:0] alu_ctrl;
    logic             alu_illegal;
    ctrl_t            ctrl;

    mc_alu_dec u_alu_dec (
        .state    (state_q),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .alu_ctrl (alu_ctrl),
        .illegal  (alu_illegal)
    );

    // This wait cycle would be the TIMEOUT_CYCLES-th without mem_ready
    assign timeout = !bus.mem_ready &&
                     ((CNT_X_W'(wait_cnt_q) + CNT_X_W'(1)) == TIMEOUT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Cleared on any state change, so every wait state starts counting from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_d != state_q) begin
            wait_cnt_q <= '0;
        end else if (is_wait_state(state_q)) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        ctrl          = '0;
        ctrl.alu_ctrl = alu_ctrl;
        case (state_q)
            S_RST: begin
                ctrl.alu_ctrl = ALU_AND;
                state_d       = S_FETCH;
            end
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ctrl.alu_src_a = SRC_A_OLD_PC;
                ctrl.alu_src_b = SRC_B_IMM;
                case (bus.opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_RTYPE:           state_d = S_EXEC_R;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    default:             state_d = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                state_d        = (bus.opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                state_d        = alu_illegal ? S_FAULT : S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.pc_src    = 1'b1;
                case (bus.funct3)
                    F3_BEQ: begin
                        ctrl.pc_write   = bus.zero;
                        ctrl.instr_done = 1'b1;
                        state_d         = S_FETCH;
                    end
`ifdef BNE_SUPPORT_EN
                    F3_BNE: begin
                        ctrl.pc_write   = ~bus.zero;
                        ctrl.instr_done = 1'b1;
                        state_d         = S_FETCH;
                    end
`endif
                    default: state_d = S_FAULT;
                endcase
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_ctrl   = ctrl.alu_ctrl;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.fault      = ctrl.fault;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected-cycle model checked every cycle.
module tb_multicycle_ctrl;

    localparam int TO = 15;

    localparam logic [3:0] ST_RST = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                           ST_MEM_ADDR = 4'd3, ST_MEM_RD = 4'd4, ST_MEM_WB = 4'd5,
                           ST_MEM_WR = 4'd6, ST_EXEC_R = 4'd7, ST_R_WB = 4'd8,
                           ST_BRANCH = 4'd9, ST_FAULT = 4'd10;
    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011,
                           OP_R = 7'b0110011, OP_BR = 7'b1100011;

    localparam logic [31:0] I_LD  = 32'h0080B283;
    localparam logic [31:0] I_SD  = 32'h0050B823;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_BNE = 32'h00209463;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_AND = 32'h0020F1B3;
    localparam logic [31:0] I_OR  = 32'h0020E1B3;
    localparam logic [31:0] I_XOR = 32'h0020C1B3;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcs, irw, mrd, mwr, iod, rw, m2r;
        logic [1:0] a, b;
        logic [3:0] alu;
        logic       done, flt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_seen, mwr_seen, rw_seen, pcw_seen, fetch_seen;
    obs_t exp_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        obs_t o;
        o.st = bus.state;      o.pcw = bus.pc_write;   o.pcs = bus.pc_src;
        o.irw = bus.ir_write;  o.mrd = bus.mem_read;   o.mwr = bus.mem_write;
        o.iod = bus.i_or_d;    o.rw = bus.reg_write;   o.m2r = bus.mem_to_reg;
        o.a = bus.alu_src_a;   o.b = bus.alu_src_b;    o.alu = bus.alu_ctrl;
        o.done = bus.instr_done; o.flt = bus.fault;
        return o;
    endfunction

    function automatic obs_t ob(input logic [3:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Compare DUT against the expected cycle queued for this clock period
    always @(negedge clk) begin
        obs_t d, e;
        d = dut_obs();
        if (d.done) done_seen++;
        if (d.mwr) mwr_seen++;
        if (d.rw) rw_seen++;
        if (d.pcw) pcw_seen++;
        if (d.st == ST_FETCH) fetch_seen++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL cycle @%0t: got %h required %h", $time, d, e);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic clr();
        done_seen = 0; mwr_seen = 0; rw_seen = 0; pcw_seen = 0; fetch_seen = 0;
    endtask

    task automatic step(input logic rdy, input obs_t e);
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Waits until ready or until the timeout budget is exhausted
    task automatic mem_phase(input obs_t base, input obs_t on_rdy, input int w, output bit flt);
        flt = (w >= TO);
        for (int i = 0; i < (flt ? TO : w); i++) step(1'b0, base);
        if (!flt) step(1'b1, on_rdy);
    endtask

    task automatic fault_tail();
        obs_t e;
        e = ob(ST_FAULT);
        e.flt = 1'b1;
        for (int i = 0; i < 3; i++) step(rnd_bit(), e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("reset_async_zero", int'(dut_obs()), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(rnd_bit(), ob(ST_RST));
    endtask

    // Expands one instruction into its expected per-cycle outputs
    task automatic run_instr(input logic [31:0] ir, input logic z, input int fw, input int mw,
                             output bit faulted);
        obs_t e, r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [3:0] alu;
        bit legal;
        opc = ir[6:0];
        f3  = ir[14:12];
        bus.opcode = opc; bus.funct3 = f3; bus.funct7_5 = ir[30]; bus.zero = z;
        faulted = 1'b0;
        e = ob(ST_FETCH); e.mrd = 1'b1; e.b = 2'b01; e.alu = A_ADD;
        r = e; r.irw = 1'b1; r.pcw = 1'b1;
        mem_phase(e, r, fw, faulted);
        if (faulted) begin
            fault_tail();
            return;
        end
        e = ob(ST_DECODE); e.a = 2'b10; e.b = 2'b10; e.alu = A_ADD;
        step(rnd_bit(), e);
        if (opc == OP_LD || opc == OP_SD) begin
            e = ob(ST_MEM_ADDR); e.a = 2'b01; e.b = 2'b10; e.alu = A_ADD;
            step(rnd_bit(), e);
            if (opc == OP_LD) begin
                e = ob(ST_MEM_RD); e.mrd = 1'b1; e.iod = 1'b1;
                mem_phase(e, e, mw, faulted);
                if (!faulted) begin
                    e = ob(ST_MEM_WB); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
                    step(rnd_bit(), e);
                end
            end else begin
                e = ob(ST_MEM_WR); e.mwr = 1'b1; e.iod = 1'b1;
                r = e; r.done = 1'b1;
                mem_phase(e, r, mw, faulted);
            end
        end else if (opc == OP_R) begin
            legal = 1'b1;
            case (f3)
                3'd0:    alu = ir[30] ? A_SUB : A_ADD;
                3'd7:    alu = A_AND;
                3'd6:    alu = A_OR;
                default: begin alu = A_AND; legal = 1'b0; end
            endcase
            e = ob(ST_EXEC_R); e.a = 2'b01; e.alu = alu;
            step(rnd_bit(), e);
            if (legal) begin
                e = ob(ST_R_WB); e.rw = 1'b1; e.done = 1'b1;
                step(rnd_bit(), e);
            end else begin
                faulted = 1'b1;
            end
        end else if (opc == OP_BR) begin
            e = ob(ST_BRANCH); e.a = 2'b01; e.alu = A_SUB; e.pcs = 1'b1;
            legal = 1'b1;
            if (f3 == 3'd0) e.pcw = z;
`ifdef BNE_SUPPORT_EN
            else if (f3 == 3'd1) e.pcw = ~z;
`endif
            else legal = 1'b0;
            e.done = legal;
            step(rnd_bit(), e);
            faulted = !legal;
        end else begin
            faulted = 1'b1;
        end
        if (faulted) fault_tail();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        clr();
        @(posedge clk);
        #1;
        do_reset();

        clr(); run_instr(I_LD, 1'b0, 0, 0, f);
        check("ld_done_pulses", done_seen, 1);
        check("ld_reg_write", rw_seen, 1);

        clr(); run_instr(I_SD, 1'b0, 0, 3, f);
        check("sd_mem_write_cycles", mwr_seen, 4);
        check("sd_reg_write", rw_seen, 0);
        check("sd_done_pulses", done_seen, 1);

        clr(); run_instr(I_BEQ, 1'b1, 0, 0, f);
        check("beq_taken_pc_writes", pcw_seen, 2);
        clr(); run_instr(I_BEQ, 1'b0, 0, 0, f);
        check("beq_not_taken_pc_writes", pcw_seen, 1);

        clr(); run_instr(I_SUB, 1'b0, 0, 0, f);
        check("sub_reg_write", rw_seen, 1);
        run_instr(I_ADD, 1'b0, 14, 0, f);
        run_instr(I_AND, 1'b1, 1, 0, f);
        run_instr(I_OR, 1'b0, 0, 0, f);

        clr(); run_instr(I_LD, 1'b0, 2, TO - 1, f);
        check("ld_ready_on_timeout_cycle", int'(f), 0);

        run_instr(I_BNE, 1'b1, 0, 0, f);
        if (f) do_reset();
        run_instr(I_XOR, 1'b0, 0, 0, f);
        check("xor_faults", int'(f), 1);
        do_reset();

        run_instr(I_BAD, 1'b0, 0, 0, f);
        check("bad_opcode_fault_sticky", int'(bus.fault), 1);
        do_reset();
        check("fault_cleared_by_reset", int'(bus.fault), 0);

        clr(); run_instr(I_ADD, 1'b0, TO, 0, f);
        check("fetch_timeout_wait_cycles", fetch_seen, TO);
        do_reset();

        run_instr(I_LD, 1'b0, 0, 20, f);
        check("mem_rd_timeout", int'(f), 1);
        do_reset();

        // Reset asserted in the middle of a stalled store
        begin
            obs_t e;
            bus.opcode = I_SD[6:0]; bus.funct3 = I_SD[14:12]; bus.funct7_5 = I_SD[30];
            e = ob(ST_FETCH); e.mrd = 1'b1; e.b = 2'b01; e.alu = A_ADD; e.irw = 1'b1; e.pcw = 1'b1;
            step(1'b1, e);
            e = ob(ST_DECODE); e.a = 2'b10; e.b = 2'b10; e.alu = A_ADD;
            step(1'b1, e);
            e = ob(ST_MEM_ADDR); e.a = 2'b01; e.b = 2'b10; e.alu = A_ADD;
            step(1'b1, e);
            e = ob(ST_MEM_WR); e.mwr = 1'b1; e.iod = 1'b1;
            step(1'b0, e);
            step(1'b0, e);
            bus.mem_ready = 1'b0;
            #1;
            check("mid_store_mem_write", int'(bus.mem_write), 1);
            do_reset();
        end
        clr(); run_instr(I_LD, 1'b0, 0, 0, f);
        check("restart_ld_done", done_seen, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
